mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the instruction-fetch (IF) and data-memory (DM) stages of the 5-stage RV32I pipeline.
- The control unit's MemRead/MemWrite drive the DM request side; the PC/fetch logic drives the IF side.
- One transaction is in flight at a time. DM has priority, with a starvation limit that guarantees fetch progress.
- Pipeline stall logic uses the gnt/rvalid handshakes to freeze stages.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-side signals of the IF/DM shared memory port.
// master = requesters plus memory model, slave = the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  dm_req;
    logic                  dm_we;
    logic [DATA_W/8-1:0]   dm_be;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic                  dm_gnt;
    logic                  dm_rvalid;
    logic [DATA_W-1:0]     dm_rdata;

    logic                  mem_cs;
    logic [DATA_W/8-1:0]   mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for IF/DM: DM priority with a starvation cap for IF.
// Grant is combinational in IDLE; rvalid pulses MEM_LAT+1 cycles after grant; requests stall while busy.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int          BE_W = DATA_W / 8;
    localparam logic [3:0]  LAT  = 4'(MEM_LAT);
    localparam logic [3:0]  LIM  = 4'(STARVE_LIM);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          r_starve_cnt;
    logic                r_owner_dm;
    logic                r_owner_we;
    logic                r_if_rvalid;
    logic                r_dm_rvalid;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;

    logic                w_idle;
    logic                w_if_win;
    logic                w_dm_win;
    logic                w_issue;
    logic                w_done;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [BE_W-1:0]     w_mem_we;

    // Reset is gated into the decision so nothing is granted while rst_n is low.
    assign w_idle   = rst_n && (r_state == S_IDLE);
    assign w_if_win = w_idle && bus.if_req && (!bus.dm_req || (r_starve_cnt == LIM));
    assign w_dm_win = w_idle && bus.dm_req && !w_if_win;
    assign w_issue  = w_if_win || w_dm_win;
    assign w_done   = (r_state == S_WAIT) && (r_cnt == LAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_done)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_we    = '0;
        if (w_dm_win) begin
            w_mem_addr  = bus.dm_addr;
            w_mem_wdata = bus.dm_wdata;
            w_mem_we    = bus.dm_we ? bus.dm_be : '0;
        end else if (w_if_win) begin
            w_mem_addr  = bus.if_addr;
        end
        bus.if_gnt    = w_if_win;
        bus.dm_gnt    = w_dm_win;
        bus.mem_cs    = w_issue;
        bus.mem_addr  = w_mem_addr;
        bus.mem_wdata = w_mem_wdata;
        bus.mem_we    = w_mem_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_starve_cnt <= '0;
            r_owner_dm   <= 1'b0;
            r_owner_we   <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_dm_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
        end else begin
            r_if_rvalid <= w_done && !r_owner_dm;
            r_dm_rvalid <= w_done &&  r_owner_dm;

            if (w_issue) begin
                r_cnt      <= 4'd1;
                r_owner_dm <= w_dm_win;
                r_owner_we <= w_dm_win && bus.dm_we;
            end else if (w_done) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 4'd1;
            end

            // Count DM wins that bypassed a waiting fetch; any IF win resets the debt.
            if (w_if_win) begin
                r_starve_cnt <= '0;
            end else if (w_dm_win && bus.if_req && (r_starve_cnt != LIM)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            if (w_done && !r_owner_dm) begin
                r_if_rdata <= bus.mem_rdata;
            end
            if (w_done && r_owner_dm) begin
                r_dm_rdata <= r_owner_we ? '0 : bus.mem_rdata;
            end
        end
    end

    assign bus.if_rvalid = r_if_rvalid;
    assign bus.dm_rvalid = r_dm_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_LIM = 4;
    localparam int NCYC       = 600;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mrd [0:NCYC-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_be    = '0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.mem_rdata = '0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        settle();
        checks++;
        if (bus.if_gnt !== 1'b1) begin
            errors++; $display("FAIL reset_pre_gnt got %b exp 1", bus.if_gnt);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.if_gnt, bus.dm_gnt, bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_wdata,
             bus.if_rvalid, bus.dm_rvalid, bus.if_rdata, bus.dm_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_async got gnt=%b%b cs=%b we=%h addr=%h wd=%h rv=%b%b ifr=%h dmr=%h exp all 0",
                     bus.if_gnt, bus.dm_gnt, bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                     bus.if_rvalid, bus.dm_rvalid, bus.if_rdata, bus.dm_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            checks++;
            if ({bus.if_gnt, bus.mem_cs} !== 2'b00) begin
                errors++; $display("FAIL reset_hold_gnt got %b exp 00", {bus.if_gnt, bus.mem_cs});
            end
        end
        tick();
        idle_inputs();
        rst_n = 1'b1;
        settle();
    endtask

    task automatic test_single_fetch();
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        settle();
        checks++;
        if ({bus.if_gnt, bus.dm_gnt, bus.mem_cs, bus.mem_addr, bus.mem_we, bus.mem_wdata}
            !== {1'b1, 1'b0, 1'b1, 32'h100, 4'h0, 32'h0}) begin
            errors++;
            $display("FAIL fetch_issue got gnt=%b%b cs=%b addr=%h we=%h wd=%h exp 10 1 100 0 0",
                     bus.if_gnt, bus.dm_gnt, bus.mem_cs, bus.mem_addr, bus.mem_we, bus.mem_wdata);
        end
        tick();
        bus.if_req = 1'b0;
        settle();
        checks++;
        if ({bus.if_gnt, bus.mem_cs, bus.if_rvalid} !== 3'b000) begin
            errors++; $display("FAIL fetch_wait1 got %b exp 000", {bus.if_gnt, bus.mem_cs, bus.if_rvalid});
        end
        tick();
        bus.mem_rdata = 32'hDEADBEEF;
        settle();
        checks++;
        if (bus.if_rvalid !== 1'b0) begin
            errors++; $display("FAIL fetch_wait2 got rvalid=%b exp 0", bus.if_rvalid);
        end
        tick();
        bus.mem_rdata = 32'h11111111;
        settle();
        checks++;
        if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            errors++; $display("FAIL fetch_done got rv=%b data=%h exp 1 deadbeef", bus.if_rvalid, bus.if_rdata);
        end
        tick();
        settle();
        checks++;
        if ({bus.if_rvalid, bus.if_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL fetch_after got rv=%b data=%h exp 0 deadbeef", bus.if_rvalid, bus.if_rdata);
        end
    endtask

    task automatic test_collision();
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h300;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h2000;
        settle();
        checks++;
        if ({bus.if_gnt, bus.dm_gnt, bus.mem_addr, bus.mem_we} !== {1'b0, 1'b1, 32'h2000, 4'h0}) begin
            errors++; $display("FAIL coll_issue got gnt=%b%b addr=%h we=%h exp 01 2000 0",
                               bus.if_gnt, bus.dm_gnt, bus.mem_addr, bus.mem_we);
        end
        tick();
        bus.dm_req = 1'b0;
        settle();
        checks++;
        if ({bus.if_gnt, bus.dm_gnt} !== 2'b00) begin
            errors++; $display("FAIL coll_wait got gnt=%b%b exp 00", bus.if_gnt, bus.dm_gnt);
        end
        tick();
        bus.mem_rdata = 32'hCAFE0001;
        settle();
        tick();
        bus.mem_rdata = 32'h0;
        settle();
        checks++;
        if ({bus.dm_rvalid, bus.dm_rdata, bus.if_rvalid, bus.if_gnt, bus.dm_gnt, bus.mem_cs, bus.mem_addr}
            !== {1'b1, 32'hCAFE0001, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300}) begin
            errors++;
            $display("FAIL coll_handover got dmrv=%b dmr=%h ifrv=%b gnt=%b%b cs=%b addr=%h exp 1 cafe0001 0 10 1 300",
                     bus.dm_rvalid, bus.dm_rdata, bus.if_rvalid, bus.if_gnt, bus.dm_gnt, bus.mem_cs, bus.mem_addr);
        end
        tick();
        bus.if_req = 1'b0;
        tick();
        bus.mem_rdata = 32'h55AA55AA;
        tick();
        settle();
        checks++;
        if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'h55AA55AA}) begin
            errors++; $display("FAIL coll_if_done got rv=%b data=%h exp 1 55aa55aa", bus.if_rvalid, bus.if_rdata);
        end
    endtask

    task automatic test_store();
        tick();
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_be    = 4'b0011;
        bus.dm_addr  = 32'h40;
        bus.dm_wdata = 32'h12345678;
        settle();
        checks++;
        if ({bus.dm_gnt, bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_wdata}
            !== {1'b1, 1'b1, 4'b0011, 32'h40, 32'h12345678}) begin
            errors++; $display("FAIL store_issue got gnt=%b cs=%b we=%b addr=%h wd=%h exp 1 1 0011 40 12345678",
                               bus.dm_gnt, bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        idle_inputs();
        tick();
        bus.mem_rdata = 32'hFFFFFFFF;
        tick();
        settle();
        checks++;
        if ({bus.dm_rvalid, bus.dm_rdata, bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'h0, 1'b0, 32'h55AA55AA}) begin
            errors++; $display("FAIL store_done got dmrv=%b dmr=%h ifrv=%b ifr=%h exp 1 0 0 55aa55aa",
                               bus.dm_rvalid, bus.dm_rdata, bus.if_rvalid, bus.if_rdata);
        end
    endtask

    task automatic test_starvation();
        int grants[$];
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h700;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h800;
        for (int i = 0; i < 30; i++) begin
            settle();
            if (bus.if_gnt === 1'b1) grants.push_back(1);
            if (bus.dm_gnt === 1'b1) grants.push_back(2);
            tick();
        end
        idle_inputs();
        checks++;
        if (grants.size() != 10) begin
            errors++; $display("FAIL starve_count got %0d exp 10", grants.size());
        end
        for (int k = 0; k < grants.size() && k < 10; k++) begin
            checks++;
            if (grants[k] != (((k % (STARVE_LIM + 1)) == STARVE_LIM) ? 1 : 2)) begin
                errors++; $display("FAIL starve_seq[%0d] got %0d exp %0d (1=IF 2=DM)", k, grants[k],
                                   ((k % (STARVE_LIM + 1)) == STARVE_LIM) ? 1 : 2);
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_wait();
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h500;
        settle();
        checks++;
        if (bus.if_gnt !== 1'b1) begin
            errors++; $display("FAIL rstw_issue got %b exp 1", bus.if_gnt);
        end
        tick();
        bus.if_req = 1'b0;
        #1 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h600;
        settle();
        checks++;
        if ({bus.if_gnt, bus.mem_cs, bus.mem_addr, bus.if_rvalid, bus.if_rdata}
            !== {1'b1, 1'b1, 32'h600, 1'b0, 32'h0}) begin
            errors++; $display("FAIL rstw_regrant got gnt=%b cs=%b addr=%h rv=%b ifr=%h exp 1 1 600 0 0",
                               bus.if_gnt, bus.mem_cs, bus.mem_addr, bus.if_rvalid, bus.if_rdata);
        end
        tick();
        bus.if_req = 1'b0;
        settle();
        checks++;
        if (bus.if_rvalid !== 1'b0) begin
            errors++; $display("FAIL rstw_no_stale got rv=%b exp 0", bus.if_rvalid);
        end
        tick();
        bus.mem_rdata = 32'h00600600;
        settle();
        checks++;
        if (bus.if_rvalid !== 1'b0) begin
            errors++; $display("FAIL rstw_wait got rv=%b exp 0", bus.if_rvalid);
        end
        tick();
        settle();
        checks++;
        if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'h00600600}) begin
            errors++; $display("FAIL rstw_done got rv=%b data=%h exp 1 00600600", bus.if_rvalid, bus.if_rdata);
        end
        tick();
    endtask

    task automatic test_random();
        int          next_free = 0;
        int          starve    = 0;
        bit          pend      = 0;
        int          pend_cyc  = 0;
        bit          pend_dm   = 0;
        bit          pend_we   = 0;
        bit          if_gdone  = 0;
        bit          dm_gdone  = 0;
        logic [31:0] exp_ifr   = '0;
        logic [31:0] exp_dmr   = '0;
        bit          ei, ed, eirv, edrv;
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_we;

        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            tick();
            if (if_gdone) begin
                bus.if_req  = 1'($urandom_range(0, 1));
                bus.if_addr = $urandom;
            end else if (!bus.if_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.if_req  = 1'b1;
                    bus.if_addr = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                bus.if_req = 1'b0;
            end
            if (dm_gdone || (!bus.dm_req && $urandom_range(0, 2) == 0)) begin
                bus.dm_req   = dm_gdone ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.dm_we    = 1'($urandom_range(0, 1));
                bus.dm_be    = 4'($urandom_range(0, 15));
                bus.dm_addr  = $urandom;
                bus.dm_wdata = $urandom;
            end else if (bus.dm_req && $urandom_range(0, 15) == 0) begin
                bus.dm_req = 1'b0;
            end
            mrd[c] = $urandom;
            bus.mem_rdata = mrd[c];
            settle();

            ei = (c >= next_free) && bus.if_req && (!bus.dm_req || starve == STARVE_LIM);
            ed = (c >= next_free) && bus.dm_req && !ei;
            e_addr = ed ? bus.dm_addr : (ei ? bus.if_addr : 32'h0);
            e_wd   = ed ? bus.dm_wdata : 32'h0;
            e_we   = (ed && bus.dm_we) ? bus.dm_be : 4'h0;
            eirv   = pend && (pend_cyc == c) && !pend_dm;
            edrv   = pend && (pend_cyc == c) &&  pend_dm;
            if (eirv) exp_ifr = mrd[c - 1];
            if (edrv) exp_dmr = pend_we ? 32'h0 : mrd[c - 1];
            if (pend && pend_cyc == c) pend = 0;

            checks++;
            if ({bus.if_gnt, bus.dm_gnt, bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_wdata}
                !== {ei, ed, ei | ed, e_we, e_addr, e_wd}) begin
                errors++;
                $display("FAIL rand_issue c=%0d got gnt=%b%b cs=%b we=%h addr=%h wd=%h exp %b%b %b %h %h %h",
                         c, bus.if_gnt, bus.dm_gnt, bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                         ei, ed, ei | ed, e_we, e_addr, e_wd);
            end
            checks++;
            if ({bus.if_rvalid, bus.dm_rvalid, bus.if_rdata, bus.dm_rdata} !== {eirv, edrv, exp_ifr, exp_dmr}) begin
                errors++;
                $display("FAIL rand_resp c=%0d got rv=%b%b ifr=%h dmr=%h exp %b%b %h %h",
                         c, bus.if_rvalid, bus.dm_rvalid, bus.if_rdata, bus.dm_rdata, eirv, edrv, exp_ifr, exp_dmr);
            end

            if (ei || ed) begin
                pend      = 1;
                pend_cyc  = c + MEM_LAT + 1;
                pend_dm   = ed;
                pend_we   = ed && bus.dm_we;
                next_free = c + MEM_LAT + 1;
                if (ei) starve = 0;
                else if (bus.if_req && starve < STARVE_LIM) starve++;
            end
            if_gdone = ei;
            dm_gdone = ed;
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_collision();
        test_store();
        test_starvation();
        test_reset_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
